pc_fetch: RTL and testbench
===========================

Name: pc_fetch

Overview:
Instruction fetch stage for the picoMIPS. Holds the program counter and drives the combinational program memory address. Latches the returned instruction word into an instruction register for the downstream decoder. Supports relative and absolute branches with a one-slot squash, downstream stall, and halt/resume.

Parameters:
DATA_WIDTH, 8, immediate/data field width; also the branch_target width
ADDR_WIDTH, 5, register-address field width
PMEM_WIDTH, 5, program-memory address width (32 words)
INST_WIDTH, 6, opcode field width
RESET_PC, 0, PC value loaded on reset (PMEM_WIDTH bits)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
pmem_addr  output  PMEM_WIDTH  address to program memory; equals the PC register
pmem_dout  input  IW  instruction word from program memory, combinational in pmem_addr; IW = INST_WIDTH+2*ADDR_WIDTH+DATA_WIDTH (24)
stall  input  1  downstream not consuming ir this cycle
branch_en  input  1  decoder: the instruction in ir is a taken branch
branch_rel  input  1  1 = PC-relative target, 0 = absolute target
branch_target  input  DATA_WIDTH  signed offset (rel) or absolute address (abs, low PMEM_WIDTH bits used)
halt_req  input  1  decoder: the instruction in ir is HALT
resume  input  1  leave HALT
ir  output  IW  instruction register
ir_valid  output  1  ir holds a live instruction
ir_pc  output  PMEM_WIDTH  address the instruction in ir was fetched from
halted  output  1  high while in HALT

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high (rst sampled on the clk rising edge).
- Reset values: pc=RESET_PC, ir=0, ir_valid=0, ir_pc=0, halted=0, state=RUN.
- States:
  - RUN: fetch active.
  - HALT: pc frozen, ir_valid=0, halted=1.
- Fetch latency: 1 cycle. In RUN with no event: ir<=pmem_dout, ir_pc<=pc, ir_valid<=1, pc<=pc+1.
  - The first valid ir (mem[RESET_PC]) appears on the first edge after rst deasserts.
- Event qualification: branch_en and halt_req are honoured only when ir_valid=1; otherwise ignored.
- Priority per cycle: rst > halt_req > branch_en > stall > normal fetch.
- halt_req (RUN): state<=HALT, ir_valid<=0, pc<=ir_pc+1. Any simultaneous branch_en is ignored.
- branch_en (RUN): ignores stall, since the decoder has consumed ir.
  - pc<=target, ir_valid<=0; this squashes the sequential fetch.
  - The target instruction is valid in ir 2 edges after the branch cycle.
  - Relative target = ir_pc+1+sign-extended branch_target, truncated to PMEM_WIDTH (modulo 2^PMEM_WIDTH).
  - Absolute target = branch_target[PMEM_WIDTH-1:0].
- stall (RUN, no branch/halt): pc, ir, ir_pc, ir_valid all hold.
- HALT: halt_req, branch_en and stall are ignored.
  - resume=1: state<=RUN, no fetch that edge.
  - Next edge: normal fetch at the frozen pc.
- Wrap-around: pc+1 from 2^PMEM_WIDTH-1 goes to 0. Relative targets wrap the same way; no error is flagged.
- Reset mid-operation (stall, HALT, pending squash): all state returns to reset values on that edge.
- Invariant: in RUN with ir_valid=1 and no stall, pc==ir_pc+1 (mod 2^PMEM_WIDTH).

Decomposition:
- picomips_pkg holds:
  - localparam IW.
  - Field slice constants: OPC_MSB/LSB [23:18], RD [17:13], RS [12:8], IMM [7:0].
  - typedef enum logic {RUN, HALT} fetch_state_t.
- Flat module, no sub-module. The pmem instance is connected at the CPU top level, not inside pc_fetch.

Test Plan:
1. Reset then free-run with pmem preloaded mem[i]=i*0x010101 -> ir=0x000000,0x010101,0x020202 on consecutive edges; ir_pc 0,1,2; ir_valid=1 from edge 1.
2. Run to pc=31 -> ir_pc 30,31,0,1; ir=mem[31] then mem[0]; no bubble.
3. Relative branch at ir_pc=10 with branch_target=0xF8 (-8) -> next ir_valid=0; then ir_pc=3, ir=mem[3]. Repeat at ir_pc=2 with -8 -> target 27 (wrap).
4. Absolute branch branch_rel=0, target=0x1D, asserted together with stall=1 -> stall ignored; bubble, then ir_pc=29. Same branch with ir_valid=0 -> ignored, sequential fetch.
5. stall for 3 cycles at ir_pc=5 -> ir/ir_pc/ir_valid/pmem_addr constant; on release ir_pc=6 next edge.
6. halt_req with branch_en at ir_pc=7 -> halted=1, ir_valid=0, pmem_addr=8; resume -> halted=0, ir_pc=8 one edge later. rst during HALT or stall -> all outputs to reset values next edge.

Source files
------------

// File: rtl/picomips_pkg.sv
// Shared picoMIPS definitions: instruction word layout and fetch-stage state type.
package picomips_pkg;

  localparam int DATA_WIDTH_P = 8;
  localparam int ADDR_WIDTH_P = 5;
  localparam int INST_WIDTH_P = 6;
  localparam int IW = INST_WIDTH_P + 2 * ADDR_WIDTH_P + DATA_WIDTH_P;

  // Instruction word field positions: opcode | rd | rs | imm
  localparam int OPC_MSB = 23;
  localparam int OPC_LSB = 18;
  localparam int RD_MSB  = 17;
  localparam int RD_LSB  = 13;
  localparam int RS_MSB  = 12;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch.sv
// picoMIPS fetch stage: program counter, instruction register, branch squash,
// downstream stall and halt/resume.
module pc_fetch
  import picomips_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int PMEM_WIDTH = 5,
  parameter int INST_WIDTH = 6,
  parameter logic [PMEM_WIDTH-1:0] RESET_PC = '0,
  localparam int IR_W = INST_WIDTH + 2 * ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [PMEM_WIDTH-1:0] pmem_addr,
  input  logic [IR_W-1:0]       pmem_dout,
  input  logic                  stall,
  input  logic                  branch_en,
  input  logic                  branch_rel,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic [IR_W-1:0]       ir,
  output logic                  ir_valid,
  output logic [PMEM_WIDTH-1:0] ir_pc,
  output logic                  halted
);

  localparam int SUM_W = DATA_WIDTH + PMEM_WIDTH;
  localparam logic [PMEM_WIDTH-1:0] PC_ONE = 1;

  fetch_state_t          state_q, state_d;
  logic [PMEM_WIDTH-1:0] pc_q, pc_d;
  logic [IR_W-1:0]       ir_q, ir_d;
  logic                  ir_valid_q, ir_valid_d;
  logic [PMEM_WIDTH-1:0] ir_pc_q, ir_pc_d;

  logic [SUM_W-1:0]      rel_sum;
  logic [PMEM_WIDTH-1:0] branch_dest;
  logic                  unused_rel_hi;

  // Relative target is computed wide with a sign-extended offset, then wraps mod 2^PMEM_WIDTH
  assign rel_sum = {{DATA_WIDTH{1'b0}}, ir_pc_q}
                 + {{DATA_WIDTH{1'b0}}, PC_ONE}
                 + {{PMEM_WIDTH{branch_target[DATA_WIDTH-1]}}, branch_target};
  assign unused_rel_hi = ^rel_sum[SUM_W-1:PMEM_WIDTH];
  assign branch_dest = branch_rel ? rel_sum[PMEM_WIDTH-1:0]
                                  : branch_target[PMEM_WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    ir_pc_d    = ir_pc_q;
    case (state_q)
      RUN: begin
        if (halt_req && ir_valid_q) begin
          state_d    = HALT;
          ir_valid_d = 1'b0;
          pc_d       = ir_pc_q + PC_ONE;
        end else if (branch_en && ir_valid_q) begin
          // The decoder has already consumed ir, so a branch overrides stall
          pc_d       = branch_dest;
          ir_valid_d = 1'b0;
        end else if (!stall) begin
          ir_d       = pmem_dout;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          pc_d       = pc_q + PC_ONE;
        end
      end
      HALT: begin
        ir_valid_d = 1'b0;
        if (resume) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      ir_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      ir_pc_q    <= ir_pc_d;
    end
  end

  assign pmem_addr = pc_q;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign ir_pc     = ir_pc_q;
  assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_pc_fetch.sv
// Directed and randomized checks of pc_fetch against a cycle-level model of the
// fetch rules, with a combinational program memory held in the bench.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  pmem_addr;
  logic [23:0] pmem_dout;
  logic        stall = 1'b0;
  logic        branch_en = 1'b0;
  logic        branch_rel = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic [23:0] ir;
  logic        ir_valid;
  logic [4:0]  ir_pc;
  logic        halted;

  logic [23:0] mem [32];
  int checks = 0;
  int failures = 0;

  // Reference model state
  int          m_pc, m_irpc;
  logic [23:0] m_ir;
  bit          m_v, m_halt;

  always #5 clk = ~clk;

  assign pmem_dout = mem[pmem_addr];

  pc_fetch dut (
    .clk(clk), .rst(rst), .pmem_addr(pmem_addr), .pmem_dout(pmem_dout),
    .stall(stall), .branch_en(branch_en), .branch_rel(branch_rel),
    .branch_target(branch_target), .halt_req(halt_req), .resume(resume),
    .ir(ir), .ir_valid(ir_valid), .ir_pc(ir_pc), .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Next-state of the fetch stage from the architectural rules, priority order
  task automatic model_edge();
    int off;
    if (rst) begin
      m_pc = 0; m_ir = '0; m_irpc = 0; m_v = 0; m_halt = 0;
    end else if (m_halt) begin
      m_v = 0;
      if (resume) m_halt = 0;
    end else if (halt_req && m_v) begin
      m_halt = 1; m_v = 0; m_pc = (m_irpc + 1) % 32;
    end else if (branch_en && m_v) begin
      off  = (branch_target >= 8'h80) ? int'(branch_target) - 256 : int'(branch_target);
      m_pc = branch_rel ? ((m_irpc + 1 + off) & 31) : (int'(branch_target) & 31);
      m_v  = 0;
    end else if (!stall) begin
      m_ir = mem[m_pc]; m_irpc = m_pc; m_v = 1; m_pc = (m_pc + 1) % 32;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("pmem_addr", 32'(pmem_addr), 32'(m_pc));
    chk("ir",        32'(ir),        32'(m_ir));
    chk("ir_valid",  32'(ir_valid),  32'(m_v));
    chk("ir_pc",     32'(ir_pc),     32'(m_irpc));
    chk("halted",    32'(halted),    32'(m_halt));
    $display("t=%0t rst=%0b st=%0b br=%0b/%0b tgt=%02h hq=%0b rs=%0b | pc=%0d ir=%06h v=%0b irpc=%0d h=%0b",
             $time, rst, stall, branch_en, branch_rel, branch_target, halt_req, resume,
             pmem_addr, ir, ir_valid, ir_pc, halted);
  endtask

  task automatic idle();
    rst = 0; stall = 0; branch_en = 0; branch_rel = 0; branch_target = 8'h00;
    halt_req = 0; resume = 0;
  endtask

  // Free-run until the given ir_pc is valid in ir; bounded
  task automatic run_to(input int target);
    bit hit;
    hit = 0;
    idle();
    for (int i = 0; i < 70 && !hit; i++) begin
      step();
      if (ir_valid && int'(ir_pc) == target) hit = 1;
    end
    chk("run_to_reached", 32'(hit), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 24'(i * 24'h010101);
    m_pc = 0; m_ir = '0; m_irpc = 0; m_v = 0; m_halt = 0;
    idle();
    rst = 1;
    step(); step();
    chk("reset_valid", 32'(ir_valid), 32'd0);

    // 1. first fetches after reset
    idle();
    step();
    chk("first_ir", 32'(ir), 32'h000000);
    chk("first_valid", 32'(ir_valid), 32'd1);
    step();
    chk("second_ir", 32'(ir), 32'h010101);
    step();
    chk("third_irpc", 32'(ir_pc), 32'd2);

    // 2. wrap-around without a bubble
    run_to(30);
    step();
    chk("wrap_ir31", 32'(ir), 32'h1F1F1F);
    step();
    chk("wrap_irpc0", 32'(ir_pc), 32'd0);
    chk("wrap_valid", 32'(ir_valid), 32'd1);

    // 3. relative branches, including wrap below zero
    run_to(10);
    branch_en = 1; branch_rel = 1; branch_target = 8'hF8;
    step();
    chk("rel_bubble", 32'(ir_valid), 32'd0);
    idle();
    step();
    chk("rel_irpc", 32'(ir_pc), 32'd3);
    chk("rel_ir", 32'(ir), 32'h030303);
    run_to(2);
    branch_en = 1; branch_rel = 1; branch_target = 8'hF8;
    step();
    idle();
    step();
    chk("rel_wrap_irpc", 32'(ir_pc), 32'd27);

    // 4. absolute branch overrides stall; branch with no valid ir is ignored
    run_to(12);
    branch_en = 1; branch_rel = 0; branch_target = 8'h1D; stall = 1;
    step();
    chk("abs_bubble", 32'(ir_valid), 32'd0);
    branch_en = 1; branch_rel = 0; branch_target = 8'h05; stall = 0;
    step();
    chk("abs_irpc", 32'(ir_pc), 32'd29);
    chk("abs_ignored_valid", 32'(ir_valid), 32'd1);

    // 5. three-cycle stall
    run_to(5);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_irpc", 32'(ir_pc), 32'd5);
      chk("stall_addr", 32'(pmem_addr), 32'd6);
    end
    idle();
    step();
    chk("stall_release", 32'(ir_pc), 32'd6);

    // 6. halt beats branch, resume, reset during halt and stall
    run_to(7);
    halt_req = 1; branch_en = 1; branch_target = 8'h00;
    step();
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_addr", 32'(pmem_addr), 32'd8);
    halt_req = 1; branch_en = 1; stall = 1;
    step();
    chk("halt_hold", 32'(halted), 32'd1);
    idle();
    resume = 1;
    step();
    chk("resume_flag", 32'(halted), 32'd0);
    chk("resume_nofetch", 32'(ir_valid), 32'd0);
    idle();
    step();
    chk("resume_irpc", 32'(ir_pc), 32'd8);
    run_to(11);
    halt_req = 1;
    step();
    idle();
    rst = 1;
    step();
    chk("rst_halt_flag", 32'(halted), 32'd0);
    chk("rst_halt_addr", 32'(pmem_addr), 32'd0);
    run_to(4);
    stall = 1;
    step();
    rst = 1;
    step();
    chk("rst_stall_irpc", 32'(ir_pc), 32'd0);
    chk("rst_stall_valid", 32'(ir_valid), 32'd0);

    // Randomized phase with fresh memory contents
    for (int i = 0; i < 32; i++) mem[i] = 24'($urandom);
    idle();
    for (int n = 0; n < 400; n++) begin
      rst           = ($urandom_range(0, 99) < 2);
      stall         = ($urandom_range(0, 99) < 25);
      branch_en     = ($urandom_range(0, 99) < 15);
      branch_rel    = $urandom_range(0, 1) == 1;
      branch_target = 8'($urandom);
      halt_req      = ($urandom_range(0, 99) < 5);
      resume        = ($urandom_range(0, 99) < 30);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
